kij_seq_ctrl: RTL



---
 rtl/core_pkg.sv | 91 +++++++++
 rtl/kij_seq_ctrl_inst_pack.sv | 29 ++
 rtl/kij_seq_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the kij sequencer: geometry, instruction-bus bit map and FSM states.
// Pure declarations; no logic, no latency, no flow control.
package core_pkg;

  localparam int INST_W  = 35;
  localparam int ADDR_W  = 11;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int LEN_NIJ = 36;
  localparam int LEN_KIJ = 9;
  localparam int GAP_CYC = 10;
  localparam logic [ADDR_W-1:0] W_BASE = 11'h400;

  localparam int CNT_W = 7;
  localparam int T_W   = 6;
  localparam int KIJ_W = 4;

  localparam int B_BYPASS    = 34;
  localparam int B_ACC       = 33;
  localparam int B_CEN_PMEM  = 32;
  localparam int B_WEN_PMEM  = 31;
  localparam int B_A_PMEM_HI = 30;
  localparam int B_A_PMEM_LO = 20;
  localparam int B_CEN_XMEM  = 19;
  localparam int B_WEN_XMEM  = 18;
  localparam int B_A_XMEM_HI = 17;
  localparam int B_A_XMEM_LO = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_IFIFO_WR  = 5;
  localparam int B_IFIFO_RD  = 4;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXECUTE   = 1;
  localparam int B_LOAD      = 0;

  // Final cnt value of each timed state (state lasts LAST+1 cycles).
  localparam logic [CNT_W-1:0] W_L0_LAST   = CNT_W'(COL);
  localparam logic [CNT_W-1:0] K_LOAD_LAST = CNT_W'(ROW + COL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] A_L0_LAST   = CNT_W'(LEN_NIJ);
  localparam logic [CNT_W-1:0] EXEC_LAST   = CNT_W'(ROW + COL + LEN_NIJ - 1);
  localparam logic [CNT_W-1:0] K_LOAD_RD   = CNT_W'(ROW);
  localparam logic [CNT_W-1:0] W_ADDR_CAP  = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] A_ADDR_CAP  = CNT_W'(LEN_NIJ - 1);
  localparam logic [T_W-1:0]   T_LAST      = T_W'(LEN_NIJ - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST    = KIJ_W'(LEN_KIJ - 1);

  typedef struct packed {
    logic              bypass;
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_fields_t;

  localparam inst_fields_t IDLE_FIELDS = '{
    bypass:   1'b0, acc:      1'b0,
    cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: '0,
    cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: '0,
    ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0,
    l0_rd:    1'b0, l0_wr:    1'b0, execute: 1'b0, load: 1'b0
  };

  localparam logic [INST_W-1:0] IDLE_INST =
      (35'd1 << B_CEN_PMEM) | (35'd1 << B_WEN_PMEM) |
      (35'd1 << B_CEN_XMEM) | (35'd1 << B_WEN_XMEM);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_K_LOAD,
    S_GAP,
    S_A_L0,
    S_EXEC,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/kij_seq_ctrl_inst_pack.sv
// inst_pack: places named instruction fields at their bus positions.
// Purely combinational, zero latency, no flow control.
module inst_pack
  import core_pkg::*;
(
  input  inst_fields_t      fields,
  output logic [INST_W-1:0] inst
);

  always_comb begin
    inst                           = '0;
    inst[B_BYPASS]                 = fields.bypass;
    inst[B_ACC]                    = fields.acc;
    inst[B_CEN_PMEM]               = fields.cen_pmem;
    inst[B_WEN_PMEM]               = fields.wen_pmem;
    inst[B_A_PMEM_HI:B_A_PMEM_LO]  = fields.a_pmem;
    inst[B_CEN_XMEM]               = fields.cen_xmem;
    inst[B_WEN_XMEM]               = fields.wen_xmem;
    inst[B_A_XMEM_HI:B_A_XMEM_LO]  = fields.a_xmem;
    inst[B_OFIFO_RD]               = fields.ofifo_rd;
    inst[B_IFIFO_WR]               = fields.ififo_wr;
    inst[B_IFIFO_RD]               = fields.ififo_rd;
    inst[B_L0_RD]                  = fields.l0_rd;
    inst[B_L0_WR]                  = fields.l0_wr;
    inst[B_EXECUTE]                = fields.execute;
    inst[B_LOAD]                   = fields.load;
  end

endmodule

// File: rtl/kij_seq_ctrl.sv
// kij_seq_ctrl: one start runs weight load, execute and psum drain for every kernel position.
// All outputs registered one cycle behind state; DRAIN stalls on !ofifo_valid with no timeout.
module kij_seq_ctrl
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [KIJ_W-1:0]  kij_idx
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [T_W-1:0]     t;
  logic [KIJ_W-1:0]   kij;
  logic               cnt_end;
  inst_fields_t       fields;
  logic [INST_W-1:0]  inst_nxt;
  logic [ADDR_W-1:0]  w_ofs;
  logic [ADDR_W-1:0]  a_ofs;
  logic [ADDR_W-1:0]  w_row_base;
  logic [ADDR_W-1:0]  pmem_base;

  always_comb begin
    cnt_end = 1'b0;
    case (state)
      S_W_L0:   cnt_end = (cnt == W_L0_LAST);
      S_K_LOAD: cnt_end = (cnt == K_LOAD_LAST);
      S_GAP:    cnt_end = (cnt == GAP_LAST);
      S_A_L0:   cnt_end = (cnt == A_L0_LAST);
      S_EXEC:   cnt_end = (cnt == EXEC_LAST);
      default:  cnt_end = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_W_L0;
      S_W_L0:   if (cnt_end) state_nxt = S_K_LOAD;
      S_K_LOAD: if (cnt_end) state_nxt = S_GAP;
      S_GAP:    if (cnt_end) state_nxt = S_A_L0;
      S_A_L0:   if (cnt_end) state_nxt = S_EXEC;
      S_EXEC:   if (cnt_end) state_nxt = S_DRAIN;
      S_DRAIN:  if (ofifo_valid && (t == T_LAST)) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (kij == KIJ_LAST) ? S_FIN : S_W_L0;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      t     <= '0;
      kij   <= '0;
    end else begin
      state <= state_nxt;

      if ((state_nxt != state) || (state == S_IDLE) || (state == S_DRAIN))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if ((state != S_DRAIN) || (state_nxt != S_DRAIN))
        t <= '0;
      else if (ofifo_valid)
        t <= t + 1'b1;

      if ((state == S_NEXT) && (state_nxt == S_W_L0))
        kij <= kij + 1'b1;
      else if ((state == S_IDLE) || (state == S_FIN))
        kij <= '0;
    end
  end

  // Read addresses saturate on the trailing cycle that flushes the SRAM read latency into L0.
  always_comb begin
    w_ofs      = (cnt > W_ADDR_CAP) ? ADDR_W'(W_ADDR_CAP) : ADDR_W'(cnt);
    a_ofs      = (cnt > A_ADDR_CAP) ? ADDR_W'(A_ADDR_CAP) : ADDR_W'(cnt);
    w_row_base = W_BASE + ADDR_W'(kij) * ADDR_W'(COL);
    pmem_base  = ADDR_W'(kij) * ADDR_W'(LEN_NIJ);
  end

  always_comb begin
    fields = IDLE_FIELDS;
    case (state)
      S_W_L0: begin
        fields.cen_xmem = 1'b0;
        fields.a_xmem   = w_row_base + w_ofs;
        fields.l0_wr    = (cnt != '0);
      end
      S_K_LOAD: begin
        fields.load  = 1'b1;
        fields.l0_rd = (cnt < K_LOAD_RD);
      end
      S_A_L0: begin
        fields.cen_xmem = (cnt > A_ADDR_CAP);
        fields.a_xmem   = a_ofs;
        fields.l0_wr    = (cnt != '0);
      end
      S_EXEC: begin
        fields.execute = 1'b1;
        fields.l0_rd   = 1'b1;
      end
      S_DRAIN: begin
        fields.bypass = 1'b1;
        fields.a_pmem = pmem_base + ADDR_W'(t);
        if (ofifo_valid) begin
          fields.ofifo_rd = 1'b1;
          fields.cen_pmem = 1'b0;
          fields.wen_pmem = 1'b0;
        end
      end
      default: fields = IDLE_FIELDS;
    endcase
  end

  inst_pack u_inst_pack (
    .fields (fields),
    .inst   (inst_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      inst    <= IDLE_INST;
      busy    <= 1'b0;
      done    <= 1'b0;
      kij_idx <= '0;
    end else begin
      inst    <= inst_nxt;
      busy    <= (state != S_IDLE) && (state != S_FIN);
      done    <= (state == S_FIN);
      kij_idx <= kij;
    end
  end

endmodule
